// File: rtl/spi_rx_pkg.sv
// Shared types and default sizes for the SPI packet receiver.
package spi_rx_pkg;

   localparam int PACKET_SIZE = 24;
   localparam int NUM_TRACKS  = 1;

   typedef struct packed {
      logic [15:0] pitch;
      logic [7:0]  amplitude;
   } track_cmd_t;

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_t;

endpackage

// File: rtl/spi_packet_rx_if.sv
// SPI link pins plus the committed-packet outputs of spi_packet_rx.
interface spi_packet_rx_if #(
   parameter int PACKET_SIZE = spi_rx_pkg::PACKET_SIZE,
   parameter int NUM_TRACKS  = spi_rx_pkg::NUM_TRACKS
) ();

   logic                              cs;
   logic                              sck;
   logic                              sdi;
   logic                              sdo;
   logic [PACKET_SIZE*NUM_TRACKS-1:0] packet;
   logic                              packet_valid;
   logic                              frame_error;
   logic                              busy;

   modport master (output cs, sck, sdi,
                   input  sdo, packet, packet_valid, frame_error, busy);
   modport slave  (input  cs, sck, sdi,
                   output sdo, packet, packet_valid, frame_error, busy);

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses from one extra delay flop.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic i_d,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_dly;

   // No reset: the chain tracks the pin during reset so a level held across
   // reset release does not look like a fresh edge.
   always_ff @(posedge clk) begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_dly  <= r_sync[SYNC_STAGES-1];
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  =  o_level & ~r_dly;
   assign o_fall  = ~o_level &  r_dly;

endmodule

// File: rtl/spi_packet_rx.sv
// SPI control-packet receiver: deserialize MSB-first, length-check, atomic commit.
// Optional echo of the previous packet on sdo when SPI_RX_ECHO_EN is defined.
module spi_packet_rx #(
   parameter int NUM_TRACKS  = spi_rx_pkg::NUM_TRACKS,
   parameter int PACKET_SIZE = spi_rx_pkg::PACKET_SIZE,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   spi_packet_rx_if.slave   bus
);

   import spi_rx_pkg::*;

   localparam int TOTAL = PACKET_SIZE * NUM_TRACKS;
   localparam int CW    = $clog2(TOTAL + 1);

   logic w_cs_lvl, w_cs_rise, w_cs_fall;
   logic w_sck_lvl, w_sck_rise, w_sck_fall;
   logic w_sdi, w_sdi_rise, w_sdi_fall;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
      .clk(clk), .i_d(bus.cs), .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
      .clk(clk), .i_d(bus.sck), .o_level(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdi (
      .clk(clk), .i_d(bus.sdi), .o_level(w_sdi), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall));

   logic [4:0] w_unused_edges;
   assign w_unused_edges = {w_cs_lvl, w_sck_lvl, w_sdi_rise, w_sdi_fall, w_sck_fall};

   rx_state_t        r_state;
   logic [TOTAL-1:0] r_shift;
   logic [TOTAL-1:0] r_packet;
   logic [CW-1:0]    r_count;
   logic             r_ovf;
   logic             r_cs_pend;
   logic             r_valid;
   logic             r_err;
   logic             r_busy;
   logic             w_start;

   assign w_start = (r_state == IDLE) && (w_cs_rise || r_cs_pend);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_packet  <= '0;
         r_count   <= '0;
         r_ovf     <= 1'b0;
         r_cs_pend <= 1'b0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state   <= SHIFT;
                  r_shift   <= '0;
                  r_count   <= '0;
                  r_ovf     <= 1'b0;
                  r_cs_pend <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            SHIFT: begin
               // cs fall takes priority over a coincident sck rise
               if (w_cs_fall) begin
                  r_state <= CHECK;
               end else if (w_sck_rise) begin
                  if (r_count < CW'(TOTAL)) begin
                     r_shift <= {r_shift[TOTAL-2:0], w_sdi};
                     r_count <= r_count + CW'(1);
                  end else begin
                     r_ovf <= 1'b1;
                  end
               end
            end
            CHECK: begin
               if (r_count == CW'(TOTAL) && !r_ovf) begin
                  r_packet <= r_shift;
                  r_valid  <= 1'b1;
               end else begin
                  r_err <= 1'b1;
               end
               if (w_cs_rise) r_cs_pend <= 1'b1;
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.packet       = r_packet;
   assign bus.packet_valid = r_valid;
   assign bus.frame_error  = r_err;
   assign bus.busy         = r_busy;

`ifdef SPI_RX_ECHO_EN
   logic [TOTAL-1:0] r_echo;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_echo <= '0;
      end else if (w_start) begin
         r_echo <= r_packet;
      end else if (r_state == SHIFT && w_sck_fall) begin
         r_echo <= {r_echo[TOTAL-2:0], 1'b0};
      end
   end

   assign bus.sdo = (r_state == SHIFT) & r_echo[TOTAL-1];
`else
   assign bus.sdo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_packet_rx.sv
// Drives one SPI link into a 1-track and a 4-track receiver and checks both
// against a frame-level model (length verdict, latency, busy window, echo).
module tb_spi_packet_rx;
   import spi_rx_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cs = 1'b0, sck = 1'b0, sdi = 1'b0;
   always #5 clk = ~clk;

   spi_packet_rx_if #(.PACKET_SIZE(24), .NUM_TRACKS(1)) bus1 ();
   spi_packet_rx_if #(.PACKET_SIZE(24), .NUM_TRACKS(4)) bus4 ();

   assign bus1.cs = cs;  assign bus1.sck = sck;  assign bus1.sdi = sdi;
   assign bus4.cs = cs;  assign bus4.sck = sck;  assign bus4.sdi = sdi;

   spi_packet_rx #(.NUM_TRACKS(1), .PACKET_SIZE(24), .SYNC_STAGES(2)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave));
   spi_packet_rx #(.NUM_TRACKS(4), .PACKET_SIZE(24), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4.slave));

   logic [95:0] a_pkt [2];
   logic        a_pv [2], a_fe [2], a_busy [2], a_sdo [2];
   always_comb begin
      a_pkt[0] = 96'(bus1.packet);  a_pkt[1] = bus4.packet;
      a_pv[0]  = bus1.packet_valid; a_pv[1]  = bus4.packet_valid;
      a_fe[0]  = bus1.frame_error;  a_fe[1]  = bus4.frame_error;
      a_busy[0] = bus1.busy;        a_busy[1] = bus4.busy;
      a_sdo[0] = bus1.sdo;          a_sdo[1] = bus4.sdo;
   end

   int n_cmp = 0, n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // frame-level model state
   int          TOT [2] = '{24, 96};
   logic [95:0] exp_pkt [2] = '{96'h0, 96'h0};
   logic [95:0] evt_pkt [2] = '{96'h0, 96'h0};
   logic [95:0] last_good [2] = '{96'h0, 96'h0};
   bit          evt_good [2] = '{1'b0, 1'b0};
   int          evt_cyc [2] = '{-1, -1};
   int          bf [2] = '{0, 0};
   int          bt [2] = '{0, 0};
   int          wi = 0;
   int          rst_cyc = -1;
   int          pvc [2] = '{0, 0};
   int          fec [2] = '{0, 0};
   bit          checking = 1'b0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err < 40) $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         for (int d = 0; d < 2; d++) begin
            bit hit;
            bit eb;
            hit = (cyc == evt_cyc[d]);
            if (cyc == rst_cyc) exp_pkt[d] = '0;
            if (hit && evt_good[d]) exp_pkt[d] = evt_pkt[d];
            eb = (cyc >= bf[0] && cyc < bt[0]) || (cyc >= bf[1] && cyc < bt[1]);
            chk($sformatf("packet%0d", d), a_pkt[d], exp_pkt[d]);
            chk($sformatf("valid%0d", d), 96'(a_pv[d]), 96'(hit && evt_good[d]));
            chk($sformatf("ferr%0d", d), 96'(a_fe[d]), 96'(hit && !evt_good[d]));
            chk($sformatf("busy%0d", d), 96'(a_busy[d]), 96'(eb));
            if (a_pv[d]) pvc[d]++;
            if (a_fe[d]) fec[d]++;
         end
      end
   end

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   task automatic frame(input logic [127:0] data, input int n, input int h, input bit quick,
                        input int abort_at, output logic [23:0] echo1);
      int k;
      logic [95:0] ref_ [2];
      logic eb;
      echo1 = '0;
      cs = 1'b1;
      k = cyc;
      wi ^= 1;
      // a cs rise landing on the previous frame's check cycle starts one cycle late
      bf[wi] = (k + 3 <= bt[wi^1]) ? bt[wi^1] + 1 : k + 3;
      bt[wi] = 32'h3fffffff;
      ref_[0] = last_good[0];
      ref_[1] = last_good[1];
      step(6);
      for (int i = 0; i < n; i++) begin
         sdi = data[n-1-i];
         step(h);
         sck = 1'b1;
         step(h);
         for (int d = 0; d < 2; d++) begin
`ifdef SPI_RX_ECHO_EN
            eb = (i < TOT[d]) ? ref_[d][TOT[d]-1-i] : 1'b0;
`else
            eb = 1'b0;
`endif
            chk($sformatf("sdo%0d_bit%0d", d, i), 96'(a_sdo[d]), 96'(eb));
         end
         if (i < 24) echo1[23-i] = a_sdo[0];
         sck = 1'b0;
         if (i + 1 == abort_at) begin
            reset = 1'b1;
            k = cyc;
            rst_cyc = k + 1;
            bt[wi] = k + 1;
            evt_cyc = '{-1, -1};
            last_good = '{96'h0, 96'h0};
            cs = 1'b0;
            sdi = 1'b0;
            step(6);
            reset = 1'b0;
            step(3);
            return;
         end
      end
      step(h);
      cs = 1'b0;
      k = cyc;
      bt[wi] = k + 4;
      for (int d = 0; d < 2; d++) begin
         evt_good[d] = (n == TOT[d]);
         evt_pkt[d]  = (d == 0) ? 96'(data[23:0]) : data[95:0];
         evt_cyc[d]  = k + 4;
         if (evt_good[d]) last_good[d] = evt_pkt[d];
      end
      step(quick ? 1 : 8);
   endtask

   initial begin
      logic [23:0] e;
      logic [127:0] rd;
      int p0, f0, p1, f1, n;
      int lens [6] = '{23, 24, 25, 95, 96, 97};
      track_cmd_t t;

      step(6);
      reset = 1'b0;
      step(2);
      checking = 1'b1;
      chk("reset_packet", a_pkt[0], 96'h0);
      chk("reset_busy", 96'(a_busy[0]), 96'h0);
      chk("reset_sdo", 96'(a_sdo[0]), 96'h0);

      // good 24-bit frame, 40 ns half-period
      p0 = pvc[0]; f0 = fec[0]; p1 = pvc[1]; f1 = fec[1];
      frame(128'h0114ff, 24, 4, 1'b0, -1, e);
      chk("t1_packet", a_pkt[0], 96'h0114ff);
      chk("t1_nvalid", 96'(pvc[0] - p0), 96'd1);
      chk("t1_nerr", 96'(fec[0] - f0), 96'd0);
      chk("t1_4trk_err", 96'(fec[1] - f1), 96'd1);

      // 96-bit frame for the 4-track receiver
      p0 = pvc[0]; f0 = fec[0]; p1 = pvc[1]; f1 = fec[1];
      frame(128'h0114ff0217ff0114ff0217ff, 96, 4, 1'b0, -1, e);
      t = track_cmd_t'(bus4.packet[71:48]);
      chk("t2_trk1_pitch", 96'(t.pitch), 96'h0217);
      chk("t2_trk1_amp", 96'(t.amplitude), 96'hff);
      chk("t2_nvalid", 96'(pvc[1] - p1), 96'd1);
      chk("t2_1trk_ovf", 96'(fec[0] - f0), 96'd1);
      chk("t2_1trk_held", a_pkt[0], 96'h0114ff);

      // short then long frame for the 1-track receiver
      p0 = pvc[0]; f0 = fec[0];
      frame(128'h7abcde, 23, 4, 1'b0, -1, e);
      chk("t3_nerr", 96'(fec[0] - f0), 96'd1);
      chk("t3_nvalid", 96'(pvc[0] - p0), 96'd0);
      chk("t3_packet", a_pkt[0], 96'h0114ff);
      p0 = pvc[0]; f0 = fec[0];
      frame(128'h1abcdef, 25, 3, 1'b0, -1, e);
      chk("t4_nerr", 96'(fec[0] - f0), 96'd1);
      chk("t4_packet", a_pkt[0], 96'h0114ff);

      // echo of the last committed 1-track packet
      frame(128'h5a5a5a, 24, 4, 1'b0, -1, e);
`ifdef SPI_RX_ECHO_EN
      chk("t5_echo", 96'(e), 96'h0114ff);
`else
      chk("t5_echo", 96'(e), 96'h0);
`endif
      chk("t5_packet", a_pkt[0], 96'h5a5a5a);

      // reset in the middle of a frame, then a normal frame
      frame(128'h123456, 24, 4, 1'b0, 12, e);
      chk("t6_busy", 96'(a_busy[0]), 96'h0);
      chk("t6_packet", a_pkt[0], 96'h0);
      frame(128'h0114ff, 24, 5, 1'b0, -1, e);
      chk("t6_recommit", a_pkt[0], 96'h0114ff);

      // cs rise landing on the check cycle of the previous frame
      frame(128'hc0ffee, 24, 3, 1'b1, -1, e);
      frame(128'h00beef, 24, 3, 1'b0, -1, e);
      chk("t7_b2b_packet", a_pkt[0], 96'h00beef);

      for (int r = 0; r < 16; r++) begin
         rd = {$urandom, $urandom, $urandom, $urandom};
         n = lens[$urandom_range(0, 5)];
         frame(rd, n, int'($urandom_range(3, 6)), 1'(($urandom_range(0, 3) == 0)), -1, e);
      end
      step(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
